// File: rtl/timer_device.sv
// rtl/timer_device.sv - memory-mapped countdown timer (CTRL/PRESET/COUNT) with masked interrupt
// Defining TIMER_PRESCALE_EN adds the PSC register at offset 3 and a prescale counter.
module timer_device #(
  parameter int COUNT_W    = 32,
  parameter int PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  dev_addr,
  input  logic        dev_we,
  input  logic [31:0] dev_wd,
  output logic [31:0] dev_rd,
  output logic        irq
);

  if (COUNT_W < 8 || COUNT_W > 32) begin : g_bad_count_w
    $error("timer_device: COUNT_W must be in 8..32");
  end
  if (PRESCALE_W < 1 || PRESCALE_W > 32) begin : g_bad_prescale_w
    $error("timer_device: PRESCALE_W must be in 1..32");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_INT
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         ctrl_q, ctrl_d;
  logic [COUNT_W-1:0] preset_q, preset_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               irq_flag_q, irq_flag_d;

  logic en;
  logic auto_reload;
  logic tick;
  logic wr_ctrl;
  logic wr_preset;

  assign en          = ctrl_q[0];
  // Reserved modes 1x fall back to one-shot.
  assign auto_reload = (ctrl_q[2:1] == 2'b01);
  assign wr_ctrl     = dev_we && (dev_addr == 2'd0);
  assign wr_preset   = dev_we && (dev_addr == 2'd1);

`ifdef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] psc_q, psc_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;

  assign tick = (pre_q == psc_q);

  always_comb begin
    psc_d = psc_q;
    pre_d = pre_q;
    if (state_q == ST_LOAD) begin
      pre_d = '0;
    end else if (state_q == ST_CNT && en) begin
      pre_d = tick ? '0 : pre_q + PRESCALE_W'(1);
    end
    if (dev_we && dev_addr == 2'd3) begin
      psc_d = dev_wd[PRESCALE_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc_q <= '0;
      pre_q <= '0;
    end else begin
      psc_q <= psc_d;
      pre_q <= pre_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          // Terminal at 1 (or 0) so PRESET=0 behaves like PRESET=1 and COUNT never wraps.
          if (count_q <= COUNT_W'(1)) begin
            count_d    = '0;
            irq_flag_d = 1'b1;
            state_d    = ST_INT;
          end else begin
            count_d = count_q - COUNT_W'(1);
          end
        end
      end
      ST_INT: begin
        if (auto_reload) begin
          irq_flag_d = 1'b0;
          state_d    = ST_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A CTRL store acknowledges the interrupt and overrides the one-shot EN clear.
    if (wr_ctrl) begin
      ctrl_d     = dev_wd[3:0];
      irq_flag_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d = dev_wd[COUNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    dev_rd = '0;
    case (dev_addr)
      2'd0: dev_rd = {28'd0, ctrl_q};
      2'd1: dev_rd = 32'(preset_q);
      2'd2: dev_rd = 32'(count_q);
`ifdef TIMER_PRESCALE_EN
      2'd3: dev_rd = 32'(psc_q);
`endif
      default: dev_rd = '0;
    endcase
  end

  assign irq = irq_flag_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_device.sv
// tb/tb_timer_device.sv - self-checking bench for timer_device: decode table, directed corners, random vs model
module tb_timer_device;

  logic        clk;
  logic        reset;
  logic [1:0]  dev_addr;
  logic        dev_we;
  logic [31:0] dev_wd;
  logic [31:0] dev_rd;
  logic        irq;

  timer_device dut (
    .clk      (clk),
    .reset    (reset),
    .dev_addr (dev_addr),
    .dev_we   (dev_we),
    .dev_wd   (dev_wd),
    .dev_rd   (dev_rd),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

`ifdef TIMER_PRESCALE_EN
  localparam logic [31:0] OFF3_EXP = 32'h0000_00FF;
`else
  localparam logic [31:0] OFF3_EXP = 32'h0;
`endif

  typedef struct {
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    dev_addr = a;
    dev_wd   = d;
    dev_we   = 1'b1;
    @(posedge clk);
    #1;
    dev_we   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    dev_addr = a;
    #1;
    v = dev_rd;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(1);
  endtask

  // Reference model: register values plus a coarse activity phase
  // (0 waiting for enable, 1 about to load, 2 counting down, 3 just expired).
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, m_count, m_psc, m_pre;
  logic        m_flag;
  int          m_phase;

  task automatic model_reset();
    m_ctrl = 0; m_preset = 0; m_count = 0; m_flag = 0; m_phase = 0;
    m_psc = 0; m_pre = 0;
  endtask

  task automatic model_step(input logic we, input logic [1:0] a, input logic [31:0] d);
    logic [3:0]  n_ctrl;
    logic [31:0] n_count, n_pre;
    logic        n_flag;
    int          n_phase;
    n_ctrl = m_ctrl; n_count = m_count; n_pre = m_pre; n_flag = m_flag; n_phase = m_phase;
    if (m_phase == 0) begin
      if (m_ctrl[0]) n_phase = 1;
    end else if (m_phase == 1) begin
      n_count = m_preset; n_pre = 0; n_phase = 2;
    end else if (m_phase == 2) begin
      if (!m_ctrl[0]) n_phase = 0;
      else if (m_pre != m_psc) n_pre = m_pre + 1;
      else begin
        n_pre = 0;
        if (m_count <= 1) begin
          n_count = 0; n_flag = 1; n_phase = 3;
        end else n_count = m_count - 1;
      end
    end else begin
      if (m_ctrl[2:1] == 2'b01) begin
        n_flag = 0; n_phase = 1;
      end else begin
        n_ctrl[0] = 1'b0; n_phase = 0;
      end
    end
    if (we && a == 2'd0) begin
      n_ctrl = d[3:0]; n_flag = 0;
    end
    if (we && a == 2'd1) m_preset = d;
`ifdef TIMER_PRESCALE_EN
    if (we && a == 2'd3) m_psc = d & 32'hFF;
`endif
    m_ctrl = n_ctrl; m_count = n_count; m_pre = n_pre; m_flag = n_flag; m_phase = n_phase;
  endtask

  initial begin
    logic [31:0] v;
    int pulses, first, last, gap_bad, found;

    reset = 1'b1; dev_addr = 0; dev_we = 0; dev_wd = 0;
    #12;
    rd(2'd0, v); chk("reset_ctrl_held", v, 32'h0);
    chk("reset_irq_held", {31'd0, irq}, 32'h0);
    reset = 1'b0;
    tick(1);

    // Register decode table
    vt[0]  = '{2'd0, 1'b0, 32'h0,         32'h0};
    vt[1]  = '{2'd1, 1'b0, 32'h0,         32'h0};
    vt[2]  = '{2'd2, 1'b0, 32'h0,         32'h0};
    vt[3]  = '{2'd3, 1'b0, 32'h0,         32'h0};
    vt[4]  = '{2'd2, 1'b1, 32'hFFFF_FFFF, 32'h0};
    vt[5]  = '{2'd1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vt[6]  = '{2'd3, 1'b1, 32'hFFFF_FFFF, OFF3_EXP};
    vt[7]  = '{2'd0, 1'b1, 32'h0000_0006, 32'h6};
    vt[8]  = '{2'd1, 1'b1, 32'h1234_5678, 32'h1234_5678};
    vt[9]  = '{2'd0, 1'b1, 32'hFFFF_FFFF, 32'hF};
    vt[10] = '{2'd2, 1'b0, 32'h0,         32'h0};
    for (int i = 0; i < 11; i++) begin
      if (vt[i].we) wr(vt[i].addr, vt[i].wd);
      rd(vt[i].addr, v);
      chk($sformatf("decode[%0d]", i), v, vt[i].exp);
    end
    do_reset();

    // One-shot, PRESET=5
    wr(2'd1, 5);
    wr(2'd0, 32'h9);
    tick(1);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      rd(2'd2, v); chk($sformatf("oneshot_count[%0d]", i), v, 32'(5 - i));
    end
    tick(1);
    rd(2'd2, v); chk("oneshot_count_end", v, 32'h0);
    chk("oneshot_irq", {31'd0, irq}, 32'h1);
    tick(1);
    rd(2'd0, v); chk("oneshot_ctrl_en_cleared", v, 32'h8);
    tick(3);
    chk("oneshot_irq_sticky", {31'd0, irq}, 32'h1);
    wr(2'd0, 32'h8);
    chk("oneshot_irq_ack", {31'd0, irq}, 32'h0);
    do_reset();

    // Auto-reload, PRESET=3: pulses every 5 cycles
    wr(2'd1, 3);
    wr(2'd0, 32'hB);
    pulses = 0; first = 0; last = 0; gap_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      tick(1);
      if (irq) begin
        if (pulses == 0) first = c;
        else if (c - last != 5) gap_bad++;
        last = c;
        pulses++;
      end
    end
    chk("reload_first_pulse", 32'(first), 32'd5);
    chk("reload_pulse_count", 32'(pulses), 32'd8);
    chk("reload_gap_errors", 32'(gap_bad), 32'd0);
    do_reset();

    // Masked one-shot, PRESET=2
    wr(2'd1, 2);
    wr(2'd0, 32'h1);
    found = 0;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      if (irq) found++;
    end
    chk("mask_irq_seen", 32'(found), 32'd0);
    rd(2'd2, v); chk("mask_count_zero", v, 32'h0);
    do_reset();

    // Stop mid-count at COUNT=50
    wr(2'd1, 100);
    wr(2'd0, 32'h3);
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      rd(2'd2, v);
      if (v == 50) found = 1;
      else tick(1);
    end
    chk("stop_reach50", v, 32'd50);
    wr(2'd0, 32'h2);
    tick(3);
    rd(2'd2, v); chk("stop_count_hold", v, 32'd49);
    rd(2'd0, v); chk("stop_ctrl", v, 32'h2);
    tick(5);
    rd(2'd2, v); chk("stop_count_still", v, 32'd49);
    do_reset();

    // Async reset with a pending interrupt, then during CNT
    wr(2'd1, 1);
    wr(2'd0, 32'h9);
    tick(4);
    chk("areset_pre_irq", {31'd0, irq}, 32'h1);
    wr(2'd1, 50);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_irq", {31'd0, irq}, 32'h0);
    rd(2'd0, v); chk("areset_ctrl", v, 32'h0);
    rd(2'd1, v); chk("areset_preset", v, 32'h0);
    reset = 1'b0;
    tick(1);
    wr(2'd1, 50);
    wr(2'd0, 32'h9);
    tick(5);
    rd(2'd2, v); chk("areset_cnt_before", v, 32'd47);
    reset = 1'b1;
    #1;
    rd(2'd2, v); chk("areset_count", v, 32'h0);
    reset = 1'b0;
    tick(1);

    // Collision: CTRL store on the INT-exit edge
    wr(2'd1, 1);
    wr(2'd0, 32'h9);
    tick(1);
    wr(2'd1, 4);
    rd(2'd2, v); chk("coll_count_loaded", v, 32'd1);
    tick(1);
    chk("coll_irq_set", {31'd0, irq}, 32'h1);
    wr(2'd0, 32'h9);
    rd(2'd0, v); chk("coll_ctrl", v, 32'h9);
    chk("coll_irq_cleared", {31'd0, irq}, 32'h0);
    tick(1);
    rd(2'd2, v); chk("coll_count_idle", v, 32'h0);
    tick(1);
    rd(2'd2, v); chk("coll_reload", v, 32'd4);
    do_reset();

`ifdef TIMER_PRESCALE_EN
    // PSC=3, PRESET=2: each COUNT value held for 4 cycles
    wr(2'd3, 3);
    wr(2'd1, 2);
    wr(2'd0, 32'h1);
    tick(1);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      rd(2'd2, v); chk($sformatf("psc_count[%0d]", i), v, (i < 4) ? 32'd2 : 32'd1);
    end
    tick(1);
    rd(2'd2, v); chk("psc_count_end", v, 32'd0);
    do_reset();
`endif

    // Random traffic against the model
    model_reset();
    for (int c = 0; c < 2500; c++) begin
      logic        we;
      logic [1:0]  a;
      logic [31:0] d;
      logic [31:0] r0, r1, r2, r3;
      logic [31:0] e3;
      we = ($urandom_range(0, 9) == 0);
      a  = 2'($urandom_range(0, 3));
      d  = $urandom;
      if (a == 2'd0) d = (d & 32'hFFFF_FFF0) | {28'd0, d[3], d[2:1], ($urandom_range(0, 3) != 0)};
      if (a == 2'd1) d = (d[4] ? 32'd0 : d[5] ? 32'(d[0]) : 32'($urandom_range(2, 6)));
      if (a == 2'd3) d = (d & 32'hFFFF_FF00) | 32'($urandom_range(0, 2));
      dev_addr = a; dev_wd = d; dev_we = we;
      @(posedge clk);
      #1;
      dev_we = 1'b0;
      model_step(we, a, d);
      rd(2'd0, r0); rd(2'd1, r1); rd(2'd2, r2); rd(2'd3, r3);
`ifdef TIMER_PRESCALE_EN
      e3 = m_psc;
`else
      e3 = 32'h0;
`endif
      checks++;
      if ({r0, r1, r2, r3, irq} !== {28'd0, m_ctrl, m_preset, m_count, e3, m_flag & m_ctrl[3]}) begin
        errors++;
        $display("FAIL random[%0d]: got ctrl=%h preset=%h count=%h off3=%h irq=%b expected ctrl=%h preset=%h count=%h off3=%h irq=%b",
                 c, r0, r1, r2, r3, irq, m_ctrl, m_preset, m_count, e3, m_flag & m_ctrl[3]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
